// File: rtl/imul_unit.sv
// Iterative shift-add multiplier for the TinyRV1 execute stage.
// Returns the low nbits of in0*in1 over a val/rdy handshake, one product bit per cycle.
module imul_unit #(
  parameter int unsigned nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] out
);

  localparam int unsigned cw = $clog2(nbits) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [nbits-1:0] a;
  logic [nbits-1:0] a_nxt;
  logic [nbits-1:0] b;
  logic [nbits-1:0] b_nxt;
  logic [nbits-1:0] result;
  logic [nbits-1:0] result_nxt;
  logic [cw-1:0]    count;
  logic [cw-1:0]    count_nxt;
  logic             irdy_q;
  logic             oval_q;
  logic             irdy_nxt;
  logic             oval_nxt;

  // State, datapath and handshake flags; handshake flags track the state they decode from.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      result <= '0;
      count  <= '0;
      irdy_q <= 1'b1;
      oval_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      result <= result_nxt;
      count  <= count_nxt;
      irdy_q <= irdy_nxt;
      oval_q <= oval_nxt;
    end
  end

  // Next-state and datapath update; inputs are only looked at in the state that uses them.
  always_comb begin
    state_nxt  = state;
    a_nxt      = a;
    b_nxt      = b;
    result_nxt = result;
    count_nxt  = count;

    case (state)
      IDLE: begin
        if (istream_val) begin
          a_nxt      = in0;
          b_nxt      = in1;
          result_nxt = '0;
          count_nxt  = '0;
          state_nxt  = CALC;
        end
      end

      CALC: begin
        if (b[0]) begin
          result_nxt = result + a;
        end
        a_nxt     = a << 1;
        b_nxt     = b >> 1;
        count_nxt = count + cw'(1);
        if (count == cw'(nbits - 1)) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        if (ostream_rdy) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    irdy_nxt = (state_nxt == IDLE);
    oval_nxt = (state_nxt == DONE);
  end

  assign istream_rdy = irdy_q;
  assign ostream_val = oval_q;
  assign out         = result;

endmodule

// File: tb/tb_imul_unit.sv
// Scoreboarded random/directed bench for imul_unit: a driver queues reference
// products, an independent monitor checks handshake timing and every presented result.
module tb_imul_unit;

  localparam int unsigned nbits = 32;

  logic             clk;
  logic             rst;
  logic             istream_val;
  logic             istream_rdy;
  logic [nbits-1:0] in0;
  logic [nbits-1:0] in1;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [nbits-1:0] out;

  int n_vec = 0;
  int n_err = 0;

  logic [nbits-1:0] exp_q[$];
  int               acc_q[$];

  imul_unit #(.nbits(nbits)) dut (
    .clk        (clk),
    .rst        (rst),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .in0        (in0),
    .in1        (in1),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy),
    .out        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: low half of the full-width mathematical product.
  function automatic logic [nbits-1:0] model(input logic [nbits-1:0] x, input logic [nbits-1:0] y);
    logic [2*nbits-1:0] p;
    p = (2*nbits)'(x) * (2*nbits)'(y);
    return p[nbits-1:0];
  endfunction

  task automatic check(input string name, input logic [nbits-1:0] act, input logic [nbits-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    int cyc;
    bit prev_acc;
    bit prev_cons;
    bit prev_oval;
    cyc = 0;
    prev_acc = 1'b0;
    prev_cons = 1'b0;
    prev_oval = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst) begin
        prev_acc  = 1'b0;
        prev_cons = 1'b0;
        prev_oval = 1'b0;
        continue;
      end
      if (prev_acc) check("rdy_drop", 32'(istream_rdy), 32'd0);
      if (prev_cons) begin
        check("rdy_back", 32'(istream_rdy), 32'd1);
        check("val_drop", 32'(ostream_val), 32'd0);
      end
      if (ostream_val) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_val: got ostream_val=1 out=%h, expected no pending product", out);
        end else begin
          if (!prev_oval && acc_q.size() > 0)
            check("latency", 32'(cyc - acc_q[0]), 32'(nbits + 1));
          check("out", out, exp_q[0]);
          check("rdy_in_done", 32'(istream_rdy), 32'd0);
          if (ostream_rdy) begin
            void'(exp_q.pop_front());
            if (acc_q.size() > 0) void'(acc_q.pop_front());
          end
        end
      end
      prev_acc = istream_val && istream_rdy;
      if (prev_acc) acc_q.push_back(cyc);
      prev_cons = ostream_val && ostream_rdy;
      prev_oval = ostream_val;
    end
  end

  // One multiply: bp = cycles of back-pressure in DONE, junk = toggle ignored inputs meanwhile.
  task automatic do_mul(input logic [nbits-1:0] x, input logic [nbits-1:0] y, input int bp, input bit junk);
    int t;
    t = 0;
    while (!istream_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!istream_rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got istream_rdy=0 for %0d cycles, expected 1", t);
      return;
    end
    istream_val = 1'b1;
    in0 = x;
    in1 = y;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    istream_val = junk;
    t = 0;
    while (!ostream_val && t < 100) begin
      if (junk) begin
        in0 = $urandom;
        in1 = $urandom;
        ostream_rdy = 1'($urandom);
      end
      @(negedge clk);
      t++;
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    if (!ostream_val) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got ostream_val=0 after %0d cycles, expected 1", t);
      return;
    end
    in0 = $urandom;
    in1 = $urandom;
    repeat (bp) begin
      if (junk) istream_val = 1'b1;
      @(negedge clk);
    end
    istream_val = 1'b0;
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
  endtask

  initial begin
    int t;
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    in0 = '0;
    in1 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset_rdy", 32'(istream_rdy), 32'd1);
    check("reset_val", 32'(ostream_val), 32'd0);
    check("reset_out", out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_mul(32'd3, 32'd4, 0, 1'b0);
    do_mul(32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_mul(32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    do_mul(32'h1234_5678, 32'd0, 0, 1'b0);
    do_mul(32'd0, 32'h9ABC_DEF0, 0, 1'b0);
    do_mul(32'd5, 32'd6, 10, 1'b0);
    do_mul(32'd9, 32'd9, 3, 1'b1);

    // Asynchronous reset in the middle of CALC cycle 15.
    t = 0;
    while (!istream_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    istream_val = 1'b1;
    in0 = 32'd7;
    in1 = 32'd11;
    exp_q.push_back(model(32'd7, 32'd11));
    @(negedge clk);
    istream_val = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rdy", 32'(istream_rdy), 32'd1);
    check("async_val", 32'(ostream_val), 32'd0);
    check("async_out", out, 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(istream_rdy), 32'd1);
    check("post_rst_out", out, 32'd0);
    do_mul(32'd2, 32'd2, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      logic [nbits-1:0] x;
      logic [nbits-1:0] y;
      x = $urandom;
      y = $urandom;
      if (i % 5 == 0) y = y & 32'h0000_00FF;
      do_mul(x, y, int'($urandom_range(0, 3)), 1'($urandom));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imul_unit.md
Name: imul_unit

Overview:
Iterative shift-add integer multiplier in the TinyRV1 execute stage, beside the single-cycle ALU.
- Consumes the same two decoded operands as the ALU.
- Produces the low nbits of the product for the MUL instruction.
- Its result is muxed with the ALU output into the X/W pipeline register.
- Uses a val/rdy handshake on both sides so control logic can stall the pipeline while a multiply is in flight.

Parameters:
nbits, 32, operand and result width (must be >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
istream_val  input  1  operands valid
istream_rdy  output  1  unit can accept operands
in0  input  nbits  multiplicand
in1  input  nbits  multiplier
ostream_val  output  1  product valid
ostream_rdy  input  1  consumer accepts product
out  output  nbits  low nbits of in0*in1

Behaviour:
- State machine has three states: IDLE, CALC, DONE.
- Datapath registers:
  - a, nbits wide, shifts left.
  - b, nbits wide, shifts right.
  - result, nbits wide.
  - count, $clog2(nbits)+1 bits.
- Reset (rst=0, asynchronous, at any time including mid-CALC or in DONE):
  - state=IDLE; a=b=result=count=0.
  - Resulting outputs: istream_rdy=1, ostream_val=0, out=0.
  - Any in-flight operation is discarded.
- Output decode (combinational from state only):
  - istream_rdy=1 only in IDLE.
  - ostream_val=1 only in DONE.
  - out=result at all times.
  - No combinational path from any input to any output.
- IDLE:
  - If istream_val && istream_rdy: a<=in0, b<=in1, result<=0, count<=0, next state CALC.
  - Otherwise remain in IDLE; registers hold.
- CALC, each cycle:
  - If b[0]: result <= result + a, modulo 2^nbits with carry discarded.
  - a <= a<<1; b <= b>>1 (logical, zero fill); count <= count+1.
  - When count == nbits-1, this is the last iteration; next state DONE.
  - Exactly nbits CALC cycles; no early termination.
- DONE:
  - Hold result.
  - If ostream_rdy: next state IDLE. Otherwise remain in DONE indefinitely, with out stable.
- Latency:
  - Operands accepted at the edge ending cycle 0.
  - ostream_val=1 from cycle nbits+1 (cycle 33 for nbits=32).
- Throughput: one multiply per nbits+2 cycles minimum.
  - A new operation cannot be accepted in the same cycle the result is consumed; one IDLE cycle is mandatory.
- Ignored inputs:
  - istream_val while not in IDLE: no effect, no queueing.
  - in0/in1 changes after acceptance: no effect.
  - ostream_rdy outside DONE: no effect.
- Signedness: two's-complement low-half product equals the unsigned low-half product, so no sign handling is needed; signed and unsigned operands give identical out.
- Overflow beyond nbits is silently truncated.
- X-safety:
  - istream_val and ostream_rdy are sampled only in the relevant state.
  - in0/in1 are sampled only on acceptance.

Test Plan:
- Reset then in0=3, in1=4, istream_val=1 for one cycle, ostream_rdy=1 -> istream_rdy drops next cycle; ostream_val=1 exactly 33 cycles after acceptance with out=0x0000000C; istream_rdy=1 the cycle after consumption.
- in0=0xFFFFFFFD (-3), in1=7 -> out=0xFFFFFFEB (-21). Then in0=0xFFFFFFFF, in1=0xFFFFFFFF -> out=0x00000001. Then in0=0x00010000, in1=0x00010000 -> out=0x00000000 (truncation).
- in0=0x12345678, in1=0 and in0=0, in1=0x9ABCDEF0 -> out=0 after the full 33-cycle latency (no early exit).
- Back-pressure: in0=5, in1=6 with ostream_rdy=0 for 10 cycles after ostream_val rises -> ostream_val stays 1, out holds 0x1E, istream_rdy stays 0; raise ostream_rdy -> IDLE next cycle.
- Hold istream_val=1 with changing in0/in1 during CALC and DONE -> ignored, product reflects only the originally accepted operands (in0=9, in1=9 -> 0x51).
- Assert rst=0 asynchronously at cycle 15 of CALC (mid-cycle, not on an edge) -> outputs immediately istream_rdy=1, ostream_val=0, out=0. After release, a new multiply 2*2 -> 0x4 with normal latency.
